// File: rtl/serial_xfer_controller.sv
// Serial transfer master: START, NUM_BYTES bytes MSB first with per-byte ACK, then STOP.
// Define SERIAL_XFER_RETRY_EN to retry a NACKed transfer up to three times before reporting ack_error.
module serial_xfer_controller #(
    parameter int NUM_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] data_in,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_error,
    output logic                   enable_clk,
    input  logic                   new_clk,
    input  logic                   rising_edge,
    input  logic                   falling_edge,
    input  logic                   middle_of_high_level,
    input  logic                   middle_of_low_level,
    output logic                   sclk,
    output logic                   sdat_out,
    output logic                   sdat_oe,
    input  logic                   sdat_in
);
    localparam int W = 8 * NUM_BYTES;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START_C = 3'd1,
        TX_BIT  = 3'd2,
        ACK     = 3'd3,
        STOP_C  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t         state_r;
    logic [W-1:0]   shift_r;
    logic [1:0]     byte_cnt_r;
    logic [2:0]     bit_cnt_r;
    logic           cond_r;      // START/STOP line level already driven in this state
    logic           last_bit_r;  // bit 0 of the current byte is on the line
    logic           sampled_r;   // ACK slot already sampled
    logic           nack_r;
`ifdef SERIAL_XFER_RETRY_EN
    logic [W-1:0]   data_r;
    logic [1:0]     retry_cnt_r;
`endif

    // Edge timing comes from the strobes; the level alone is not needed here.
    logic unused_s;
    assign unused_s = rising_edge;

    // Transfer sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_error  <= 1'b0;
            enable_clk <= 1'b0;
            sclk       <= 1'b1;
            sdat_oe    <= 1'b0;
            sdat_out   <= 1'b1;
            shift_r    <= '0;
            byte_cnt_r <= 2'd0;
            bit_cnt_r  <= 3'd0;
            cond_r     <= 1'b0;
            last_bit_r <= 1'b0;
            sampled_r  <= 1'b0;
            nack_r     <= 1'b0;
`ifdef SERIAL_XFER_RETRY_EN
            data_r      <= '0;
            retry_cnt_r <= 2'd0;
`endif
        end else begin
            done <= 1'b0;
            sclk <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= START_C;
                        busy       <= 1'b1;
                        enable_clk <= 1'b1;
                        ack_error  <= 1'b0;
                        shift_r    <= data_in;
                        byte_cnt_r <= 2'(NUM_BYTES - 1);
                        bit_cnt_r  <= 3'd7;
                        cond_r     <= 1'b0;
                        last_bit_r <= 1'b0;
                        sampled_r  <= 1'b0;
                        nack_r     <= 1'b0;
`ifdef SERIAL_XFER_RETRY_EN
                        data_r      <= data_in;
                        retry_cnt_r <= 2'd0;
`endif
                    end
                end
                START_C: begin
                    if (!cond_r) begin
                        if (middle_of_high_level) begin
                            sdat_oe  <= 1'b1;
                            sdat_out <= 1'b0;
                            cond_r   <= 1'b1;
                        end
                    end else if (falling_edge) begin
                        state_r <= TX_BIT;
                        sclk    <= new_clk;
                        cond_r  <= 1'b0;
                    end
                end
                TX_BIT: begin
                    sclk <= new_clk;
                    if (middle_of_low_level) begin
                        if (last_bit_r) begin
                            // Ninth clock slot: hand the line to the receiver.
                            state_r    <= ACK;
                            sdat_oe    <= 1'b0;
                            last_bit_r <= 1'b0;
                            sampled_r  <= 1'b0;
                        end else begin
                            sdat_oe  <= 1'b1;
                            sdat_out <= shift_r[W-1];
                            shift_r  <= {shift_r[W-2:0], 1'b0};
                            if (bit_cnt_r == 3'd0) begin
                                last_bit_r <= 1'b1;
                            end else begin
                                bit_cnt_r <= bit_cnt_r - 3'd1;
                            end
                        end
                    end
                end
                ACK: begin
                    sclk <= new_clk;
                    if (middle_of_low_level) begin
                        sdat_oe <= 1'b0;
                    end
                    if (middle_of_high_level && !sampled_r) begin
                        sampled_r <= 1'b1;
                        if (sdat_in) begin
                            nack_r <= 1'b1;
`ifndef SERIAL_XFER_RETRY_EN
                            ack_error <= 1'b1;
`endif
                        end
                    end else if (falling_edge && sampled_r) begin
                        sampled_r <= 1'b0;
                        if (!nack_r && byte_cnt_r != 2'd0) begin
                            byte_cnt_r <= byte_cnt_r - 2'd1;
                            bit_cnt_r  <= 3'd7;
                            state_r    <= TX_BIT;
                        end else begin
                            state_r <= STOP_C;
                            sclk    <= 1'b1;
                            cond_r  <= 1'b0;
                        end
                    end
                end
                STOP_C: begin
                    if (!cond_r) begin
                        if (middle_of_low_level) begin
                            sdat_oe  <= 1'b1;
                            sdat_out <= 1'b0;
                            cond_r   <= 1'b1;
                        end
                    end else if (middle_of_high_level) begin
                        sdat_oe  <= 1'b0;
                        sdat_out <= 1'b1;
                        cond_r   <= 1'b0;
`ifdef SERIAL_XFER_RETRY_EN
                        if (nack_r && retry_cnt_r != 2'd3) begin
                            state_r     <= START_C;
                            retry_cnt_r <= retry_cnt_r + 2'd1;
                            shift_r     <= data_r;
                            byte_cnt_r  <= 2'(NUM_BYTES - 1);
                            bit_cnt_r   <= 3'd7;
                            nack_r      <= 1'b0;
                        end else begin
                            ack_error  <= nack_r;
                            state_r    <= DONE;
                            enable_clk <= 1'b0;
                            done       <= 1'b1;
                        end
`else
                        state_r    <= DONE;
                        enable_clk <= 1'b0;
                        done       <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    enable_clk <= 1'b0;
                    sdat_oe    <= 1'b0;
                    sdat_out   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_xfer_controller.md
SERIAL_XFER_CONTROLLER -- requirements
Module: serial_xfer_controller

Interface
REQ-001 Parameter NUM_BYTES, default 3: number of bytes sent per transfer, range 1..4.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  transfer request; sampled only in IDLE.
REQ-005 data_in  input  8*NUM_BYTES  transfer payload; most significant byte is sent first, MSB first.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse at the end of a transfer.
REQ-008 ack_error  output  1  NACK seen in the last transfer; held until the next accepted start.
REQ-009 enable_clk  output  1  run enable to the slow clock generator.
REQ-010 new_clk, rising_edge, falling_edge, middle_of_high_level, middle_of_low_level  input  1 each  slow clock generator level and one-cycle strobes.
REQ-011 sclk  output  1  serial bus clock.
REQ-012 sdat_out, sdat_oe  output  1 each  serial data drive value and drive enable; oe=0 releases the line (reads high).
REQ-013 sdat_in  input  1  serial data line readback.

Function
REQ-014 The FSM SHALL have states IDLE, START_C, TX_BIT, ACK, STOP_C, DONE.
REQ-015 IDLE with start=1 -> START_C next cycle:
- latch data_in into a shift register;
- clear ack_error;
- load byte counter = NUM_BYTES-1 and bit counter = 7.
REQ-016 start SHALL be ignored while busy=1, and the latched data SHALL not change.
REQ-017 enable_clk SHALL be 1 in all states except IDLE and DONE.
REQ-018 sclk SHALL follow new_clk in TX_BIT and ACK; sclk SHALL be 1 in all other states.
REQ-019 START_C: on the first middle_of_high_level, drive sdat_oe=1, sdat_out=0; on the next falling_edge -> TX_BIT.
REQ-020 TX_BIT: on each middle_of_low_level:
- drive sdat_oe=1, sdat_out = current shift register MSB, then shift left by 1;
- on the middle_of_low_level after bit 0 has been driven -> ACK, with no ninth data bit driven.
REQ-021 ACK:
- on middle_of_low_level, sdat_oe=0;
- on middle_of_high_level, sample sdat_in; 1 sets ack_error.
REQ-022 On the falling_edge after the sample, with ack_error=0 and bytes remaining: decrement byte counter, bit counter = 7, -> TX_BIT.
REQ-023 On that same falling_edge, with the last byte done or ack_error=1 -> STOP_C.
REQ-024 STOP_C:
- on middle_of_low_level, sdat_oe=1, sdat_out=0;
- on the next middle_of_high_level, sdat_oe=0 -> DONE.
REQ-025 DONE: done=1 for exactly one cycle -> IDLE.
REQ-026 Strobes SHALL be acted on only in the states listed above; strobes arriving in any other state are ignored.
REQ-027 Strobe inputs SHALL be used as single-cycle enables, never as clocks.

Reset
REQ-028 reset=1 SHALL force, on the next edge:
- state IDLE;
- busy=0, done=0, ack_error=0, enable_clk=0;
- sclk=1, sdat_oe=0, sdat_out=1;
- counters and shift register to 0.
REQ-029 reset SHALL abort a transfer at any point, including mid-bit, with no STOP condition generated.

Configuration
REQ-030 With SERIAL_XFER_RETRY_EN defined:
- a NACK SHALL go STOP_C -> START_C instead of DONE, reloading the latched data;
- at most 3 retries; ack_error SHALL be set only if the final attempt NACKs;
- done SHALL pulse once per accepted start.
REQ-031 Without SERIAL_XFER_RETRY_EN, a NACK SHALL end the transfer per REQ-023, with no retry counter in the logic.

Verification
REQ-032 NUM_BYTES=3, data_in=24'h34_0C_1A, sdat_in tied 0 in ACK -> exactly 3x9 sclk pulses; serial bits 0011_0100, 0000_1100, 0001_1010; then done=1 for 1 cycle with ack_error=0.
REQ-033 sdat_in=1 at the ack of byte 1 -> STOP_C immediately after byte 1; ack_error=1; done pulses once; bytes 2-3 not sent (no macro).
REQ-034 start pulsed again mid-transfer with data_in=24'hFF_FF_FF -> original 24'h34_0C_1A completes unchanged; busy stays 1 until DONE.
REQ-035 reset asserted in TX_BIT, bit 4 of byte 2 -> next cycle: IDLE, enable_clk=0, sclk=1, sdat_oe=0; a new start works normally.
REQ-036 With SERIAL_XFER_RETRY_EN and NACK always -> 4 START conditions; then done=1 once with ack_error=1.
REQ-037 Waveform check: sdat_out and sdat_oe SHALL change only while sclk=0, except in START_C and STOP_C.
